// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-side fetch port, D-side load/store port and the shared memory port.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if;
  logic        i_v;
  logic        i_r;
  logic [31:0] i_addr;
  logic        i_rv;
  logic [31:0] i_rdata;

  logic        d_v;
  logic        d_r;
  logic [31:0] d_addr;
  logic        d_we;
  logic [2:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_rv;
  logic [31:0] d_rdata;

  logic        m_v;
  logic        m_r;
  logic [31:0] m_addr;
  logic        m_we;
  logic [2:0]  m_size;
  logic [31:0] m_wdata;
  logic        m_rv;
  logic [31:0] m_rdata;

  modport slave (
    input  i_v, i_addr, d_v, d_addr, d_we, d_size, d_wdata, m_r, m_rv, m_rdata,
    output i_r, i_rv, i_rdata, d_r, d_rv, d_rdata, m_v, m_addr, m_we, m_size, m_wdata
  );

  modport master (
    output i_v, i_addr, d_v, d_addr, d_we, d_size, d_wdata, m_r, m_rv, m_rdata,
    input  i_r, i_rv, i_rdata, d_r, d_rv, d_rdata, m_v, m_addr, m_we, m_size, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: D-side priority, bounded I-side starvation, one outstanding transaction.
// Optional response timeout with err output when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
`ifdef ARB_TIMEOUT_EN
  , output logic err
`endif
);

  if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_port_arbiter: MAX_DATA_RUN must be 1..15 and TIMEOUT >= 1");
  end

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic        owner_q;        // 1 = D-side owns the outstanding transaction
  logic [3:0]  run_cnt_q;
  logic        i_rv_q;
  logic        d_rv_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic idle;
  logic gnt_d;
  logic gnt_i;
  logic accept;

  assign idle   = (state_q == IDLE);
  assign gnt_d  = idle & bus.d_v & ~(bus.i_v & (run_cnt_q == RUN_MAX));
  assign gnt_i  = idle & bus.i_v & ~gnt_d;
  assign accept = bus.m_v & bus.m_r;

  assign bus.m_v     = gnt_d | gnt_i;
  assign bus.m_addr  = gnt_d ? bus.d_addr  : bus.i_addr;
  assign bus.m_we    = gnt_d & bus.d_we;
  assign bus.m_size  = gnt_d ? bus.d_size  : 3'd2;
  assign bus.m_wdata = gnt_d ? bus.d_wdata : 32'd0;
  assign bus.d_r     = gnt_d & bus.m_r;
  assign bus.i_r     = gnt_i & bus.m_r;

  assign bus.i_rv    = i_rv_q;
  assign bus.d_rv    = d_rv_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  assign err     = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      run_cnt_q <= 4'd0;
      i_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      i_rv_q <= 1'b0;
      d_rv_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            owner_q <= gnt_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
          // Starvation counter only tracks D wins while I is actually waiting
          if (accept && gnt_i) begin
            run_cnt_q <= 4'd0;
          end else if (!bus.i_v) begin
            run_cnt_q <= 4'd0;
          end else if (accept && gnt_d && run_cnt_q != RUN_MAX) begin
            run_cnt_q <= run_cnt_q + 4'd1;
          end
        end
        BUSY: begin
          if (bus.m_rv) begin
            state_q <= IDLE;
            if (owner_q) begin
              d_rv_q    <= 1'b1;
              d_rdata_q <= bus.m_rdata;
            end else begin
              i_rv_q    <= 1'b1;
              i_rdata_q <= bus.m_rdata;
            end
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            if (owner_q) begin
              d_rv_q    <= 1'b1;
              d_rdata_q <= 32'd0;
            end else begin
              i_rv_q    <= 1'b1;
              i_rdata_q <= 32'd0;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses queued when the memory answers, checked when rv pulses.
// Define ARB_TIMEOUT_EN to also exercise the timeout abort path.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
  logic err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARB_TIMEOUT_EN
    , .err (err)
`endif
  );

  typedef struct {
    logic        side;   // 1 = D, 0 = I
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic side, input logic [31:0] data, input logic e);
    exp_t x;
    x.side = side;
    x.data = data;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Response monitor: every rv pulse must match the oldest queued response
  always @(negedge clk) begin
    if (bus.i_rv || bus.d_rv) begin
      if (sb.size() == 0) begin
        chk("spurious_rv", 32'({bus.i_rv, bus.d_rv}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rv_side", 32'({bus.i_rv, bus.d_rv}), e.side ? 32'd1 : 32'd2);
        chk("rv_data", e.side ? bus.d_rdata : bus.i_rdata, e.data);
`ifdef ARB_TIMEOUT_EN
        chk("rv_err", 32'(err), 32'(e.err));
`endif
      end
    end
  end

  initial begin
    bus.i_v = 0; bus.i_addr = 0;
    bus.d_v = 0; bus.d_addr = 0; bus.d_we = 0; bus.d_size = 0; bus.d_wdata = 0;
    bus.m_r = 0; bus.m_rv = 0; bus.m_rdata = 0;

    tick(); tick();
    chk("rst_i_rv",    32'(bus.i_rv), 0);
    chk("rst_d_rv",    32'(bus.d_rv), 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_m_v",     32'(bus.m_v), 0);
    rst_n = 1'b1;
    tick();

    // 1: D-only load, response two cycles after accept
    bus.m_r = 1; bus.d_v = 1; bus.d_addr = 32'h100; bus.d_size = 3'd2; bus.d_we = 0;
    #1;
    chk("t1_m_v", 32'(bus.m_v), 1);
    chk("t1_d_r", 32'(bus.d_r), 1);
    chk("t1_i_r", 32'(bus.i_r), 0);
    chk("t1_m_addr", bus.m_addr, 32'h100);
    tick();
    bus.d_v = 0;
    #1;
    chk("t1_busy_m_v", 32'(bus.m_v), 0);
    tick();
    bus.m_rv = 1; bus.m_rdata = 32'hDEADBEEF;
    expect_rsp(1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    bus.m_rv = 0;
    #1;
    chk("t1_d_rv", 32'(bus.d_rv), 1);
    chk("t1_i_rv", 32'(bus.i_rv), 0);
    tick();

    // 2: both requesters held, memory answers after one cycle
    bus.i_v = 1; bus.i_addr = 32'h400; bus.d_v = 1; bus.d_addr = 32'h800;
    for (int n = 0; n < 10; n++) begin
      logic want_d;
      want_d = ((n % 5) != 4);
      #1;
      chk("t2_d_r", 32'(bus.d_r), 32'(want_d));
      chk("t2_i_r", 32'(bus.i_r), 32'(!want_d));
      if (!want_d) begin
        chk("t2_i_size", 32'(bus.m_size), 32'd2);
        chk("t2_i_we",   32'(bus.m_we), 32'd0);
        chk("t2_i_addr", bus.m_addr, 32'h400);
      end
      tick();
      if (n == 9) begin bus.i_v = 0; bus.d_v = 0; end
      bus.m_rv = 1; bus.m_rdata = 32'hA000_0000 + 32'(n);
      expect_rsp(want_d, 32'hA000_0000 + 32'(n), 1'b0);
      tick();
      bus.m_rv = 0;
    end
    tick();

    // 3: halfword store at odd address passes through unmodified
    bus.d_v = 1; bus.d_we = 1; bus.d_addr = 32'h203; bus.d_size = 3'd1; bus.d_wdata = 32'h1234;
    #1;
    chk("t3_m_we",    32'(bus.m_we), 1);
    chk("t3_m_addr",  bus.m_addr, 32'h203);
    chk("t3_m_size",  32'(bus.m_size), 1);
    chk("t3_m_wdata", bus.m_wdata, 32'h1234);
    tick();
    bus.d_v = 0; bus.d_we = 0;
    bus.m_rv = 1; bus.m_rdata = 32'h55AA;
    expect_rsp(1'b1, 32'h55AA, 1'b0);
    tick();
    bus.m_rv = 0;
    tick();

    // 4: memory stalls; held request, granted side follows inputs
    bus.m_r = 0; bus.i_v = 1; bus.i_addr = 32'h40;
    #1;
    chk("t4_i_addr", bus.m_addr, 32'h40);
    chk("t4_i_r",    32'(bus.i_r), 0);
    tick();
    bus.i_v = 0; bus.d_v = 1; bus.d_addr = 32'h300; bus.d_size = 3'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_m_v",   32'(bus.m_v), 1);
      chk("t4_d_r",   32'(bus.d_r), 0);
      chk("t4_addr",  bus.m_addr, 32'h300);
      tick();
    end
    bus.m_r = 1;
    #1;
    chk("t4_d_r_go", 32'(bus.d_r), 1);
    tick();
    bus.d_v = 0;
    bus.m_rv = 1; bus.m_rdata = 32'hC0FFEE;
    expect_rsp(1'b1, 32'hC0FFEE, 1'b0);
    tick();
    bus.m_rv = 0;
    tick();

    // 5: reset while BUSY drops the transaction; late m_rv is ignored
    bus.d_v = 1; bus.d_addr = 32'h500;
    tick();
    bus.d_v = 0;
    rst_n = 0;
    #1;
    chk("t5_rst_m_v",  32'(bus.m_v), 0);
    chk("t5_rst_d_rv", 32'(bus.d_rv), 0);
    tick();
    rst_n = 1;
    bus.m_rv = 1; bus.m_rdata = 32'hBAD0BAD0;
    tick();
    bus.m_rv = 0;
    #1;
    chk("t5_no_d_rv", 32'(bus.d_rv), 0);
    chk("t5_no_i_rv", 32'(bus.i_rv), 0);
    tick();
    bus.i_v = 1; bus.i_addr = 32'h80;
    #1;
    chk("t5_i_r", 32'(bus.i_r), 1);
    tick();
    bus.i_v = 0;
    bus.m_rv = 1; bus.m_rdata = 32'h13579BDF;
    expect_rsp(1'b0, 32'h13579BDF, 1'b0);
    tick();
    bus.m_rv = 0;
    #1;
    chk("t5_i_rv", 32'(bus.i_rv), 1);
    tick();

`ifdef ARB_TIMEOUT_EN
    // 6: no response, abort after TIMEOUT busy cycles
    bus.d_v = 1; bus.d_we = 0; bus.d_addr = 32'h600;
    tick();
    bus.d_v = 0;
    expect_rsp(1'b1, 32'd0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t6_no_early_rv", 32'(bus.d_rv), 0);
      tick();
    end
    chk("t6_d_rv",   32'(bus.d_rv), 1);
    chk("t6_err",    32'(err), 1);
    chk("t6_rdata",  bus.d_rdata, 0);
    tick(); tick(); tick();
    bus.m_rv = 1; bus.m_rdata = 32'hFEEDFACE;
    tick();
    bus.m_rv = 0;
    #1;
    chk("t6_late_ignored", 32'(bus.d_rv), 0);
    chk("t6_err_clear",    32'(err), 0);
    tick();
`endif

    tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-addressable memory port between two requesters: instruction fetch (I-side) and the memory stage's load/store path (D-side).
- Sits between the pipeline stages and the unified memory array.
- Arbitrates between requests, holds exactly one outstanding transaction, and routes the response back to the requester that owns it.
- D-side has priority. A run counter bounds how long the I-side can be starved.

Parameters:
- MAX_DATA_RUN, 4: maximum consecutive D grants while an I request is pending; range 1..15.
- TIMEOUT, 64: cycles to wait for a memory response before aborting. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_v  in  1  I-side request valid
- i_r  out  1  I-side request ready
- i_addr  in  32  fetch byte address (always a word load)
- i_rv  out  1  I-side response valid (1-cycle pulse)
- i_rdata  out  32  I-side response data
- d_v  in  1  D-side request valid
- d_r  out  1  D-side request ready
- d_addr  in  32  load/store byte address
- d_we  in  1  1 = store
- d_size  in  3  funct3 size code (0/4 byte, 1/5 half, 2 word)
- d_wdata  in  32  store data
- d_rv  out  1  D-side response valid (1-cycle pulse; loads and store acks)
- d_rdata  out  32  D-side load data
- m_v  out  1  memory request valid
- m_r  in  1  memory ready to accept
- m_addr  out  32  memory address
- m_we  out  1  memory write enable
- m_size  out  3  memory size code
- m_wdata  out  32  memory write data
- m_rv  in  1  memory response / ack valid
- m_rdata  in  32  memory read data
- err  out  1  response aborted by timeout. Exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset:
  - state = IDLE; run_cnt = 0; owner = I.
  - i_rv, d_rv, err, i_rdata, d_rdata all 0.
  - m_v, i_r, d_r are 0 because state is not IDLE-with-grant.
- FSM, two states:
  - IDLE: arbitrate.
  - BUSY: waiting for m_rv.
- Grant in IDLE (combinational):
  - gnt_d = d_v & !(i_v & run_cnt == MAX_DATA_RUN).
  - gnt_i = i_v & !gnt_d.
- Request path in IDLE:
  - m_v = gnt_d | gnt_i. m_addr, m_we, m_size and m_wdata are muxed from the granted side.
  - For an I grant: m_we = 0, m_size = 2, m_wdata = 0.
  - d_r = gnt_d & m_r; i_r = gnt_i & m_r.
  - No request is accepted in BUSY: m_v = i_r = d_r = 0.
- Accept:
  - Occurs when m_v & m_r in IDLE.
  - Latch owner; state goes to BUSY next cycle.
- run_cnt:
  - Increments on a D accept while i_v = 1, saturating at MAX_DATA_RUN.
  - Clears on an I accept, or on any IDLE cycle with i_v = 0.
- Response:
  - In BUSY, when m_rv = 1: state goes to IDLE.
  - Next cycle the owner's rv pulses for 1 cycle, with rdata registered from m_rdata.
  - The non-owner's rv stays 0.
- Latency and throughput:
  - Accept at cycle T, m_rv at T+k (k ≥ 1), owner rv at T+k+1.
  - The next accept is possible at T+k+1.
  - Peak throughput is one transaction per k+1 cycles.
- Stores:
  - d_rv pulses as an ack. d_rdata is undefined for stores but driven with m_rdata.
- Boundary conditions:
  - m_rv while in IDLE (stray or post-reset): ignored, no rv pulse.
  - d_v and i_v both high with run_cnt < MAX_DATA_RUN: D wins.
  - d_v and i_v both high with run_cnt == MAX_DATA_RUN: I wins.
  - Requester drops v before the accept: no transaction, grant is re-evaluated each cycle.
  - m_r low: the request is held. The granted side may change if inputs change; no state advances.
  - rst_n asserted mid-BUSY: state and outputs reset immediately; the outstanding transaction is dropped.
- Address and size are passed unmodified. Misaligned handling belongs to the memory.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on accept and increments each BUSY cycle.
  - When the count reaches TIMEOUT with no m_rv: state goes to IDLE, and next cycle the owner's rv pulses with rdata = 0 and err = 1.
  - err is 0 on normal responses.
  - An m_rv arriving after the abort is ignored.
- When undefined:
  - No counter and no err port.
  - BUSY waits indefinitely for m_rv.

Test Plan:
1. D-only load, d_addr = 0x100, d_size = 2, m_r = 1, m_rv 2 cycles after accept with m_rdata = 0xDEADBEEF -> d_rv pulses at accept+3 with d_rdata = 0xDEADBEEF; i_rv stays 0.
2. i_v and d_v held high continuously, MAX_DATA_RUN = 4, memory k = 1 -> grant sequence D,D,D,D,I,D,D,D,D,I; i_rv carries fetch data.
3. Store d_we = 1, d_addr = 0x203, d_size = 1, d_wdata = 0x1234 -> m_we = 1, m_addr = 0x203, m_size = 1, m_wdata = 0x1234 on accept; d_rv ack pulse after m_rv.
4. m_r = 0 for 3 cycles with d_v = 1 -> d_r = 0 and no state change; accept occurs on the first cycle m_r = 1.
5. rst_n low during BUSY, then m_rv = 1 after release -> no rv pulse; next request proceeds normally from IDLE.
6. ARB_TIMEOUT_EN, TIMEOUT = 8, no m_rv -> owner rv with err = 1 and rdata = 0 at accept+9; a late m_rv at accept+12 is ignored.
